// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - vector type encodings, micro-op record and geometry helpers
package rv32v_types_pkg;

  localparam int VLEN      = 128;
  localparam int VLMAX_W   = $clog2(VLEN) + 1;
  // log2 of the element count per register at SEW8
  localparam int LOG2_EMAX = $clog2(VLEN / 8);

  typedef enum logic [2:0] {
    LMUL_1 = 3'b000, LMUL_2 = 3'b001, LMUL_4 = 3'b010, LMUL_8 = 3'b011,
    LMUL_RSVD = 3'b100, LMUL_F8 = 3'b101, LMUL_F4 = 3'b110, LMUL_F2 = 3'b111
  } vlmul_t;

  typedef enum logic [2:0] {
    SEW_8 = 3'b000, SEW_16 = 3'b001, SEW_32 = 3'b010, SEW_64 = 3'b011,
    SEW_R4 = 3'b100, SEW_R5 = 3'b101, SEW_R6 = 3'b110, SEW_R7 = 3'b111
  } vsew_t;

  typedef enum logic {IDLE, SEQ} seq_state_t;

  typedef struct packed {
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vs1_is_vreg;
    vlmul_t      vlmul;
    vsew_t       vsew;
    logic        vill;
    logic [31:0] vl;
  } isn_t;

  typedef struct packed {
    logic [4:0]         vd;
    logic [4:0]         vs1;
    logic [4:0]         vs2;
    logic [2:0]         idx;
    logic               first;
    logic               last;
    logic [VLMAX_W-1:0] elem_start;
    logic [VLMAX_W-1:0] elem_cnt;
    logic               illegal;
  } uop_t;

  function automatic logic [3:0] lmul_regs(vlmul_t m);
    case (m)
      LMUL_2:  return 4'd2;
      LMUL_4:  return 4'd4;
      LMUL_8:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic int unsigned sew_bits(vsew_t s);
    case (s)
      SEW_8:   return 8;
      SEW_16:  return 16;
      SEW_32:  return 32;
      SEW_64:  return 64;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_uop_sequencer_if.sv
// rtl/rv32v_uop_sequencer_if.sv - instruction-in / micro-op-out handshake bundle
interface rv32v_uop_sequencer_if;
  import rv32v_types_pkg::*;

  logic               isn_valid;
  logic               isn_ready;
  logic [4:0]         vd;
  logic [4:0]         vs1;
  logic [4:0]         vs2;
  logic               vs1_is_vreg;
  logic [2:0]         vlmul_shadow;
  logic [2:0]         vsew_shadow;
  logic               vill_shadow;
  logic [31:0]        vl_shadow;
  logic               uop_valid;
  logic               uop_ready;
  logic [4:0]         uop_vd;
  logic [4:0]         uop_vs1;
  logic [4:0]         uop_vs2;
  logic [2:0]         uop_idx;
  logic               uop_first;
  logic               uop_last;
  logic [VLMAX_W-1:0] uop_elem_start;
  logic [VLMAX_W-1:0] uop_elem_cnt;
  logic               uop_illegal;

  modport master (
    output isn_valid, vd, vs1, vs2, vs1_is_vreg, vlmul_shadow, vsew_shadow, vill_shadow, vl_shadow, uop_ready,
    input  isn_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx, uop_first, uop_last,
           uop_elem_start, uop_elem_cnt, uop_illegal
  );

  modport slave (
    input  isn_valid, vd, vs1, vs2, vs1_is_vreg, vlmul_shadow, vsew_shadow, vill_shadow, vl_shadow, uop_ready,
    output isn_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx, uop_first, uop_last,
           uop_elem_start, uop_elem_cnt, uop_illegal
  );

endinterface

// File: rtl/rv32v_uop_count_calc.sv
// rtl/rv32v_uop_count_calc.sv - legality, last uop index and element range for one uop index
module rv32v_uop_count_calc
  import rv32v_types_pkg::*;
(
  input  isn_t               isn,
  input  logic [2:0]         idx,
  output logic               illegal,
  output logic [2:0]         last_idx,
  output logic [VLMAX_W-1:0] elem_start,
  output logic [VLMAX_W-1:0] elem_cnt
);

  logic [3:0]         lregs;
  logic [4:0]         align_mask;
  logic [2:0]         log2e;
  logic [VLMAX_W-1:0] e, vlmax, vl_eff, last_raw, lr_m1, rem;

  always_comb begin
    lregs      = lmul_regs(isn.vlmul);
    align_mask = 5'(lregs) - 5'd1;
    // E is a power of two, so division by E becomes a shift by log2e
    log2e      = 3'(LOG2_EMAX) - 3'(isn.vsew);
    e          = VLMAX_W'(1) << log2e;

    case (isn.vlmul)
      LMUL_2:  vlmax = e << 1;
      LMUL_4:  vlmax = e << 2;
      LMUL_8:  vlmax = e << 3;
      LMUL_F2: vlmax = e >> 1;
      LMUL_F4: vlmax = e >> 2;
      LMUL_F8: vlmax = e >> 3;
      default: vlmax = e;
    endcase

    illegal = isn.vill
            | (isn.vlmul == LMUL_RSVD)
            | (sew_bits(isn.vsew) == 0) | (sew_bits(isn.vsew) > 32)
            | (|(isn.vd & align_mask))
            | (|(isn.vs2 & align_mask))
            | (isn.vs1_is_vreg & (|(isn.vs1 & align_mask)));

    vl_eff   = (isn.vl >= 32'(vlmax)) ? vlmax : isn.vl[VLMAX_W-1:0];
    last_raw = (vl_eff == '0) ? '0 : ((vl_eff - VLMAX_W'(1)) >> log2e);
    lr_m1    = VLMAX_W'(lregs) - VLMAX_W'(1);
    last_idx = illegal ? 3'd0 : 3'((last_raw > lr_m1) ? lr_m1 : last_raw);

    elem_start = VLMAX_W'(idx) << log2e;
    rem        = vl_eff - elem_start;
    elem_cnt   = illegal ? '0 : ((rem > e) ? e : rem);
  end

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// rtl/rv32v_uop_sequencer.sv - splits a decoded vector instruction into per-register micro-ops
module rv32v_uop_sequencer
  import rv32v_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  rv32v_uop_sequencer_if.slave  bus
);

  seq_state_t         state_q;
  isn_t               isn_q, isn_src;
  uop_t               uop_q, uop_d;
  logic               accept, handshake;
  logic [2:0]         idx_src, calc_last_idx;
  logic               calc_illegal;
  logic [VLMAX_W-1:0] calc_start, calc_cnt;

  assign bus.uop_valid = (state_q == SEQ);
  assign handshake     = bus.uop_valid & bus.uop_ready;
  assign bus.isn_ready = (state_q == IDLE) | (handshake & uop_q.last);
  assign accept        = bus.isn_valid & bus.isn_ready & ~flush;

  // Next uop is computed from live inputs on accept, else from the captured instruction
  always_comb begin
    isn_src = isn_q;
    if (accept) begin
      isn_src.vd          = bus.vd;
      isn_src.vs1         = bus.vs1;
      isn_src.vs2         = bus.vs2;
      isn_src.vs1_is_vreg = bus.vs1_is_vreg;
      isn_src.vlmul       = vlmul_t'(bus.vlmul_shadow);
      isn_src.vsew        = vsew_t'(bus.vsew_shadow);
      isn_src.vill        = bus.vill_shadow;
      isn_src.vl          = bus.vl_shadow;
    end
    idx_src = accept ? 3'd0 : uop_q.idx + 3'd1;
  end

  rv32v_uop_count_calc u_calc (
    .isn        (isn_src),
    .idx        (idx_src),
    .illegal    (calc_illegal),
    .last_idx   (calc_last_idx),
    .elem_start (calc_start),
    .elem_cnt   (calc_cnt)
  );

  always_comb begin
    uop_d            = '0;
    uop_d.vd         = isn_src.vd + {2'b00, idx_src};
    uop_d.vs1        = isn_src.vs1_is_vreg ? isn_src.vs1 + {2'b00, idx_src} : isn_src.vs1;
    uop_d.vs2        = isn_src.vs2 + {2'b00, idx_src};
    uop_d.idx        = idx_src;
    uop_d.first      = (idx_src == 3'd0);
    uop_d.last       = (idx_src == calc_last_idx);
    uop_d.elem_start = calc_start;
    uop_d.elem_cnt   = calc_cnt;
    uop_d.illegal    = calc_illegal;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      isn_q   <= '0;
      uop_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else if (accept) begin
      state_q <= SEQ;
      isn_q   <= isn_src;
      uop_q   <= uop_d;
    end else if (handshake) begin
      if (uop_q.last) state_q <= IDLE;
      else            uop_q   <= uop_d;
    end
  end

  assign bus.uop_vd         = uop_q.vd;
  assign bus.uop_vs1        = uop_q.vs1;
  assign bus.uop_vs2        = uop_q.vs2;
  assign bus.uop_idx        = uop_q.idx;
  assign bus.uop_first      = uop_q.first;
  assign bus.uop_last       = uop_q.last;
  assign bus.uop_elem_start = uop_q.elem_start;
  assign bus.uop_elem_cnt   = uop_q.elem_cnt;
  assign bus.uop_illegal    = uop_q.illegal;

endmodule

// File: doc/rv32v_uop_sequencer.md
Name: rv32v_uop_sequencer

Overview:
Decode-stage block directly downstream of the vector shadow CSR. It accepts one decoded vector instruction and samples the speculative vlmul/vsew/vl/vill shadow values at acceptance. It then splits the instruction into one micro-op per vector register of the LMUL group, each with offset register indices and per-uop element range, and feeds the issue stage under a valid/ready handshake.

Parameters:
VLEN, 128, vector register width in bits (power of 2, 64..1024)
VLMAX_W, $clog2(VLEN)+1, width of element index/count fields

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
flush  in  1  decode flush (same flush that restores the shadow CSR)
isn_valid  in  1  decoded vector instruction present
isn_ready  out  1  sequencer can accept instruction this cycle
vd  in  5  destination register base
vs1  in  5  source 1 register base
vs2  in  5  source 2 register base
vs1_is_vreg  in  1  vs1 names a vector group (else scalar/imm; no offset, no alignment check)
vlmul_shadow  in  3  vlmul_t from shadow CSR
vsew_shadow  in  3  vsew_t from shadow CSR
vill_shadow  in  1  vill from shadow CSR
vl_shadow  in  32  vl from shadow CSR
uop_valid  out  1  micro-op valid
uop_ready  in  1  issue accepts micro-op
uop_vd / uop_vs1 / uop_vs2  out  5 each  base + uop_idx (uop_vs1 = vs1 unmodified when !vs1_is_vreg)
uop_idx  out  3  micro-op index within group
uop_first / uop_last  out  1 each  first / last micro-op of instruction
uop_elem_start  out  VLMAX_W  first element index = uop_idx*E
uop_elem_cnt  out  VLMAX_W  active (body) elements in this uop
uop_illegal  out  1  illegal-instruction marker, carried to mem for exception

Behaviour:
- E = VLEN/SEW; LREGS = 1,2,4,8 for vlmul 000..011; LREGS = 1 for fractional 101/110/111.
- Illegal if any of: vill_shadow; vlmul=100; vsew>=011 (SEW64 unsupported on RV32); vd, vs2, or (vs1 when vs1_is_vreg) not a multiple of LREGS. An illegal instruction emits exactly one uop: uop_illegal=1, first=last=1, elem_cnt=0.
- vl_eff = min(vl_shadow, VLMAX). Uop count N = 1 if vl_eff==0, else min(LREGS, ceil(vl_eff/E)). Tail-only registers are not issued.
- elem_cnt(i) = min(E, vl_eff - i*E). vl_eff==0 gives one uop, cnt 0.
- FSM IDLE/SEQ. Reset: IDLE; all outputs 0 except isn_ready=1.
- isn_ready = IDLE | (uop_valid & uop_ready & uop_last), combinational. Accept = isn_valid & isn_ready & !flush.
- On accept: capture operands, shadow values, and N; go to SEQ. uop 0 is valid the next cycle (latency 1). Back-to-back instructions have no bubble.
- SEQ: outputs are registered and held stable while uop_valid & !uop_ready. Each handshake increments idx. The last handshake returns to IDLE unless a new accept happens in the same cycle.
- flush takes priority over everything: next state IDLE, uop_valid=0 the next cycle, and no accept that cycle. RST mid-sequence behaves the same, asynchronously.
- Shadow inputs are sampled only at accept. Later shadow updates (a following vsetvl) do not affect an in-flight sequence.

Decomposition:
- rv32v_types_pkg: add uop_t struct (vd, vs1, vs2, idx, first, last, elem_start, elem_cnt, illegal), functions lmul_regs(vlmul_t) and sew_bits(vsew_t), and a VLEN-derived localparam helper.
- Sub-module rv32v_uop_count_calc: combinational. Computes illegal, N, and per-index elem_cnt from the captured state.

Test Plan:
- VLEN=128, LMUL=4, SEW=32, vl=16, vd=8, vs2=4 -> 4 uops, vd 8..11, vs2 4..7, start 0/4/8/12, cnt 4 each, last on idx 3.
- Same with vl=9 -> 3 uops, cnt 4,4,1, last on idx 2. With vl=0 -> 1 uop, cnt 0.
- LMUL=2, vd=9 -> single uop, illegal=1. vill_shadow=1 -> same response. LMUL=1/2, SEW=8, vl=8 -> 1 uop, cnt 8, legal.
- uop_ready low for 3 cycles at idx 1 -> all uop outputs stable; sequence resumes with idx 2 when ready rises.
- flush in cycle with idx 1 valid -> uop_valid=0 next cycle, isn_ready=1. isn_valid in the flush cycle is ignored.
- Two instructions back-to-back (LMUL=2 then LMUL=1), uop_ready tied high -> uops at cycles 1,2,3 with no gap. isn_ready is high on the cycle of the last uop handshake.
